// File: rtl/legv8_pkg.sv
// legv8_pkg: shared encodings for the LEGv8 front end.
`default_nettype none

package legv8_pkg;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;
  localparam logic [1:0] PS_JUMP   = 2'b11;

  localparam logic [63:0] LEGV8_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// pc_next_mux: next-PC selection (hold / +4 / PC-relative / register) and misalign detect.
`default_nettype none

module pc_next_mux
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [1:0]        ps_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] branch_offset_i,
  input  logic [ADDR_W-1:0] reg_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              misalign_o
);

  always_comb begin
    next_pc_o  = pc_i;
    misalign_o = 1'b0;
    case (ps_i)
      PS_INC:    next_pc_o = pc_i + ADDR_W'(4);
      PS_BRANCH: next_pc_o = pc_i + (branch_offset_i << 2);
      PS_JUMP: begin
        // Jump targets are word-aligned by truncation; low bits only flag the fault.
        next_pc_o  = {reg_target_i[ADDR_W-1:2], 2'b00};
        misalign_o = |reg_target_i[1:0];
      end
      default:   next_pc_o = pc_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches over a req/ack port and holds the word for the datapath.
`default_nettype none

module instruction_fetch_unit
  import legv8_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(LEGV8_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        PS,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PC4,
  output logic              misalign
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] next_pc;
  logic              next_misalign;

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_mux (
    .ps_i            (PS),
    .pc_i            (pc_q),
    .branch_offset_i (branch_offset),
    .reg_target_i    (reg_target),
    .next_pc_o       (next_pc),
    .misalign_o      (next_misalign)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // PS=HOLD with advance is a halt: the word stays valid and no fetch starts.
        if (advance && (PS != PS_HOLD)) begin
          pc_d       = next_pc;
          valid_d    = 1'b0;
          misalign_d = misalign_q | next_misalign;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign PC          = pc_q;
  assign PC4         = pc_q + ADDR_W'(4);
  assign misalign    = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus random stimulus against a behavioural fetch model.
`default_nettype none

module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  PS = 2'b00;
  logic [63:0] branch_offset = 64'h0;
  logic [63:0] reg_target = 64'h0;
  logic        advance = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [63:0] PC;
  logic [63:0] PC4;
  logic        misalign;

  always #5 clock = ~clock;

  instruction_fetch_unit #(
    .ADDR_W   (64),
    .RESET_PC (64'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .PS            (PS),
    .branch_offset (branch_offset),
    .reg_target    (reg_target),
    .advance       (advance),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .PC            (PC),
    .PC4           (PC4),
    .misalign      (misalign)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what the datapath should see, not how the RTL sequences it.
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_waiting;   // a fetch request is outstanding
  logic        m_started;   // first edge after reset release has occurred
  logic        m_mis;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 64'h0;
    m_instr   = 32'h0;
    m_valid   = 1'b0;
    m_waiting = 1'b0;
    m_started = 1'b0;
    m_mis     = 1'b0;
  endtask

  task automatic model_edge();
    if (!m_started) begin
      m_started = 1'b1;
      m_waiting = 1'b1;
    end else if (m_waiting) begin
      if (imem_ack) begin
        m_instr   = imem_rdata;
        m_valid   = 1'b1;
        m_waiting = 1'b0;
      end
    end else if (m_valid && advance && PS != 2'd0) begin
      if (PS == 2'd1) m_pc = m_pc + 64'd4;
      else if (PS == 2'd2) m_pc = m_pc + branch_offset * 64'd4;
      else begin
        m_pc = reg_target & ~64'd3;
        if (reg_target % 4 != 0) m_mis = 1'b1;
      end
      m_valid   = 1'b0;
      m_waiting = 1'b1;
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".req"},   {63'h0, imem_req},    {63'h0, m_waiting});
    check({where, ".addr"},  imem_addr,            m_pc);
    check({where, ".instr"}, {32'h0, instr},       {32'h0, m_instr});
    check({where, ".valid"}, {63'h0, instr_valid}, {63'h0, m_valid});
    check({where, ".pc"},    PC,                   m_pc);
    check({where, ".pc4"},   PC4,                  m_pc + 64'd4);
    check({where, ".mis"},   {63'h0, misalign},    {63'h0, m_mis});
  endtask

  task automatic step(input string where);
    @(posedge clock);
    model_edge();
    #1;
    check_all(where);
  endtask

  task automatic fetch(input int waits, input logic [31:0] data);
    advance  = 1'b0;
    imem_ack = 1'b0;
    repeat (waits) step("wait");
    imem_ack   = 1'b1;
    imem_rdata = data;
    step("ack");
    imem_ack = 1'b0;
  endtask

  task automatic retire(input logic [1:0] ps, input logic [63:0] off, input logic [63:0] rt);
    advance       = 1'b1;
    PS            = ps;
    branch_offset = off;
    reg_target    = rt;
    step("retire");
    advance = 1'b0;
  endtask

  logic [31:0] held;

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check_all("reset");
    repeat (2) @(posedge clock);
    #1 check_all("reset_hold");
    @(negedge clock) reset = 1'b1;

    // Zero-wait fetch: ack is already high when the request rises.
    imem_ack   = 1'b1;
    imem_rdata = 32'h8B020020;
    step("t1_idle");
    check("t1_req_up", {63'h0, imem_req}, 64'd1);
    step("t1_ack");
    imem_ack = 1'b0;
    check("t1_addr",  imem_addr, 64'h0);
    check("t1_instr", {32'h0, instr}, 64'h8B020020);
    check("t1_valid", {63'h0, instr_valid}, 64'd1);
    check("t1_pc4",   PC4, 64'h4);

    // Walk to PC=0x10, one fetch carrying three wait states.
    retire(2'd1, 64'h0, 64'h0); fetch(0, 32'h11111111);
    retire(2'd1, 64'h0, 64'h0); fetch(3, 32'h22222222);
    check("t2_valid_after", {63'h0, instr_valid}, 64'd1);
    retire(2'd1, 64'h0, 64'h0); fetch(1, 32'h33333333);
    retire(2'd1, 64'h0, 64'h0);
    check("t3_at10", imem_addr, 64'h10);
    fetch(0, 32'h44444444);

    retire(2'd2, -64'sd2, 64'h0);
    check("t3_branch", imem_addr, 64'h8);
    fetch(0, 32'h55555555);

    retire(2'd3, 64'h0, 64'h1003);
    check("t4_jump", imem_addr, 64'h1000);
    check("t4_mis",  {63'h0, misalign}, 64'd1);
    fetch(2, 32'h66666666);
    retire(2'd1, 64'h0, 64'h0); fetch(0, 32'h77777777);
    check("t4_mis_sticky", {63'h0, misalign}, 64'd1);

    held = instr;
    retire(2'd0, 64'h5, 64'h0);
    retire(2'd0, 64'h9, 64'h0);
    check("t5_halt_instr", {32'h0, instr}, {32'h0, held});
    check("t5_halt_valid", {63'h0, instr_valid}, 64'd1);

    // Reset in the middle of an outstanding request.
    retire(2'd1, 64'h0, 64'h0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("t5_rst_req", {63'h0, imem_req}, 64'd0);
    check("t5_rst_pc",  PC, 64'h0);
    check_all("t5_rst");
    @(negedge clock) reset = 1'b1;
    step("t5_idle");
    fetch(0, 32'hAAAA5555);

    retire(2'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(1, 32'h12345678);
    retire(2'd1, 64'h0, 64'h0);
    check("t6_wrap", imem_addr, 64'h0);
    fetch(0, 32'h87654321);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r             = 8'($urandom);
      imem_ack      = ($urandom_range(0, 2) == 0);
      imem_rdata    = $urandom;
      advance       = $urandom_range(0, 1) == 1;
      PS            = 2'($urandom);
      branch_offset = {{56{r[7]}}, r};
      reg_target    = {$urandom, $urandom};
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
